// File: rtl/des_key_sched_if.sv
// des_key_sched_if: request and key inputs, plus round count, subkey and status
// outputs, between the DES key schedule and its neighbours.
interface des_key_sched_if;
    localparam int unsigned KEY_W = 64;
    localparam int unsigned SUB_W = 48;
    localparam int unsigned CNT_W = 5;

    logic             start;
    logic             decrypt;
    logic [KEY_W-1:0] key_in;
    logic [CNT_W-1:0] cnt;
    logic [SUB_W-1:0] subkey;
    logic             busy;
    logic             key_err;

    modport master (
        output start, decrypt, key_in,
        input  cnt, subkey, busy, key_err
    );

    modport slave (
        input  start, decrypt, key_in,
        output cnt, subkey, busy, key_err
    );
endinterface

// File: rtl/des_key_sched.sv
// des_key_sched: round counter and C/D key schedule for an iterative DES datapath.
// Optional key byte-parity check is enabled by defining DES_KEY_PARITY_CHK_EN.
module des_key_sched #(
    parameter int unsigned LAST_HOLD = 1
) (
    input logic            clk,
    input logic            rst,
    des_key_sched_if.slave bus
);
    localparam int unsigned KEY_W  = 64;
    localparam int unsigned CD_W   = 56;
    localparam int unsigned HALF_W = 28;
    localparam int unsigned SUB_W  = 48;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned HOLD_W = 4;

    localparam logic [CNT_W-1:0]  CNT_IDLE  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ROUND = CNT_W'(16);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(17);
    localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(LAST_HOLD - 1);

    // PC-1 and PC-2 in DES numbering (bit 1 = MSB of the source vector)
    localparam int unsigned PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [SUB_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit i set when round i+1 shifts by two instead of one
    localparam logic [15:0] TWO_SHIFT = 16'h7EFC;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_RUN,
        PH_LAST,
        PH_BAD
    } phase_t;

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < CD_W; i++) begin
            r[CD_W-1-i] = k[KEY_W-PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [SUB_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUB_W-1:0] r;
        r = '0;
        for (int i = 0; i < SUB_W; i++) begin
            r[SUB_W-1-i] = cd[CD_W-PC2_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] v, input logic two);
        return two ? {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]}
                   : {v[HALF_W-2:0], v[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] v, input logic two);
        return two ? {v[1:0], v[HALF_W-1:2]}
                   : {v[0], v[HALF_W-1:1]};
    endfunction

`ifdef DES_KEY_PARITY_CHK_EN
    function automatic logic key_parity_ok(input logic [KEY_W-1:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < KEY_W / 8; b++) begin
            ok = ok & (^k[8*b +: 8]);
        end
        return ok;
    endfunction
`endif

    logic [CNT_W-1:0]  cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HALF_W-1:0] c_q;
    logic [HALF_W-1:0] d_q;
    logic              mode_q;
    logic              busy_q;
    logic              key_ok;
    logic [CD_W-1:0]   cd0;
    logic [HALF_W-1:0] c0;
    logic [HALF_W-1:0] d0;
    logic [3:0]        enc_idx;
    logic [3:0]        dec_idx;
    phase_t            phase;

    assign cd0     = pc1(bus.key_in);
    assign c0      = cd0[CD_W-1:HALF_W];
    assign d0      = cd0[HALF_W-1:0];
    // Encrypt at round k applies S[k+1]; decrypt undoes S[17-k]
    assign enc_idx = cnt_q[3:0];
    assign dec_idx = 4'(CNT_ROUND - cnt_q);

`ifdef DES_KEY_PARITY_CHK_EN
    assign key_ok = key_parity_ok(bus.key_in);
`else
    assign key_ok = 1'b1;
`endif

    // Phase is a pure decode of cnt, so an upset cnt value is self-correcting
    always_comb begin
        phase = PH_BAD;
        if (cnt_q == CNT_IDLE) begin
            phase = PH_IDLE;
        end else if (cnt_q <= CNT_ROUND) begin
            phase = PH_RUN;
        end else if (cnt_q == CNT_LAST) begin
            phase = PH_LAST;
        end
    end

`ifdef DES_KEY_PARITY_CHK_EN
    logic key_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_err_q <= 1'b0;
        end else begin
            key_err_q <= (phase == PH_IDLE) && bus.start && !key_ok;
        end
    end

    assign bus.key_err = key_err_q;
`else
    assign bus.key_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= CNT_IDLE;
            hold_q <= '0;
            c_q    <= '0;
            d_q    <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    // Decrypt starts from the unrotated key, which equals C16/D16
                    if (bus.start && key_ok) begin
                        mode_q <= bus.decrypt;
                        c_q    <= bus.decrypt ? c0 : rotl(c0, 1'b0);
                        d_q    <= bus.decrypt ? d0 : rotl(d0, 1'b0);
                        cnt_q  <= CNT_W'(1);
                        busy_q <= 1'b1;
                    end
                end
                PH_RUN: begin
                    cnt_q  <= cnt_q + CNT_W'(1);
                    busy_q <= 1'b1;
                    if (cnt_q != CNT_ROUND) begin
                        if (mode_q) begin
                            c_q <= rotr(c_q, TWO_SHIFT[dec_idx]);
                            d_q <= rotr(d_q, TWO_SHIFT[dec_idx]);
                        end else begin
                            c_q <= rotl(c_q, TWO_SHIFT[enc_idx]);
                            d_q <= rotl(d_q, TWO_SHIFT[enc_idx]);
                        end
                    end
                end
                PH_LAST: begin
                    if (hold_q == HOLD_END) begin
                        cnt_q  <= CNT_IDLE;
                        hold_q <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    cnt_q  <= CNT_IDLE;
                    hold_q <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt    = cnt_q;
    assign bus.busy   = busy_q;
    assign bus.subkey = pc2({c_q, d_q});

endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: directed checks of the DES round counter and subkey sequence
// against the classic 133457799BBCDFF1 key schedule.
module tb_des_key_sched;
    localparam int unsigned LAST_HOLD  = 3;
    localparam logic [63:0] KEY        = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BADPAR = 64'h133457799BBCDFF0;
    localparam logic [63:0] KEY_OTHER  = 64'h0E329232EA6D0D73;

    // K1..K16 for KEY
    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    des_key_sched_if bus ();

    des_key_sched #(.LAST_HOLD(LAST_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_start(input logic dec, input logic [63:0] key);
        bus.start   = 1'b1;
        bus.decrypt = dec;
        bus.key_in  = key;
        tick();
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", bus.cnt); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.subkey !== 48'h0) begin miscompares++; $display("FAIL reset_subkey: got %h expected 0", bus.subkey); end
        vectors++; if (bus.key_err !== 1'b0) begin miscompares++; $display("FAIL reset_key_err: got %b expected 0", bus.key_err); end
        rst = 1'b0;
        tick();
        tick();
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL idle_cnt: got %0d expected 0", bus.cnt); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_encrypt();
        apply_start(1'b0, KEY);
        for (int k = 1; k <= 16; k++) begin
            vectors++; if (bus.cnt !== 5'(k)) begin miscompares++; $display("FAIL enc_cnt: got %0d expected %0d", bus.cnt, k); end
            vectors++; if (bus.subkey !== KS[k-1]) begin miscompares++; $display("FAIL enc_subkey k=%0d: got %h expected %h", k, bus.subkey, KS[k-1]); end
            vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL enc_busy k=%0d: got %b expected 1", k, bus.busy); end
            tick();
        end
        for (int h = 0; h < int'(LAST_HOLD); h++) begin
            vectors++; if (bus.cnt !== 5'd17) begin miscompares++; $display("FAIL enc_last h=%0d: got %0d expected 17", h, bus.cnt); end
            vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL enc_last_busy h=%0d: got %b expected 1", h, bus.busy); end
            tick();
        end
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL enc_done_cnt: got %0d expected 0", bus.cnt); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL enc_done_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.subkey !== KS[15]) begin miscompares++; $display("FAIL enc_done_subkey: got %h expected %h", bus.subkey, KS[15]); end
    endtask

    task automatic test_decrypt();
        apply_start(1'b1, KEY);
        for (int k = 1; k <= 16; k++) begin
            vectors++; if (bus.cnt !== 5'(k)) begin miscompares++; $display("FAIL dec_cnt: got %0d expected %0d", bus.cnt, k); end
            vectors++; if (bus.subkey !== KS[16-k]) begin miscompares++; $display("FAIL dec_subkey k=%0d: got %h expected %h", k, bus.subkey, KS[16-k]); end
            tick();
        end
        for (int h = 0; h < int'(LAST_HOLD); h++) begin
            vectors++; if (bus.cnt !== 5'd17) begin miscompares++; $display("FAIL dec_last h=%0d: got %0d expected 17", h, bus.cnt); end
            tick();
        end
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL dec_done_cnt: got %0d expected 0", bus.cnt); end
        vectors++; if (bus.subkey !== KS[0]) begin miscompares++; $display("FAIL dec_done_subkey: got %h expected %h", bus.subkey, KS[0]); end
    endtask

    task automatic test_ignore_start();
        tick();
        apply_start(1'b0, KEY);
        for (int k = 1; k <= 16; k++) begin
            vectors++; if (bus.cnt !== 5'(k)) begin miscompares++; $display("FAIL ign_cnt: got %0d expected %0d", bus.cnt, k); end
            vectors++; if (bus.subkey !== KS[k-1]) begin miscompares++; $display("FAIL ign_subkey k=%0d: got %h expected %h", k, bus.subkey, KS[k-1]); end
            if (k == 5) begin
                bus.start   = 1'b1;
                bus.decrypt = 1'b1;
                bus.key_in  = KEY_OTHER;
            end
            tick();
            bus.start   = 1'b0;
            bus.decrypt = 1'b0;
        end
        for (int h = 0; h < int'(LAST_HOLD); h++) begin
            vectors++; if (bus.cnt !== 5'd17) begin miscompares++; $display("FAIL ign_last h=%0d: got %0d expected 17", h, bus.cnt); end
            tick();
        end
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL ign_done_cnt: got %0d expected 0", bus.cnt); end
    endtask

    task automatic test_reset_mid();
        tick();
        apply_start(1'b0, KEY);
        for (int k = 1; k < 9; k++) tick();
        vectors++; if (bus.cnt !== 5'd9) begin miscompares++; $display("FAIL mid_pre_cnt: got %0d expected 9", bus.cnt); end
        vectors++; if (bus.subkey !== KS[8]) begin miscompares++; $display("FAIL mid_pre_subkey: got %h expected %h", bus.subkey, KS[8]); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL mid_rst_cnt: got %0d expected 0", bus.cnt); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.subkey !== 48'h0) begin miscompares++; $display("FAIL mid_rst_subkey: got %h expected 0", bus.subkey); end
        vectors++; if (bus.key_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_key_err: got %b expected 0", bus.key_err); end
        tick();
        rst = 1'b0;
        tick();
        apply_start(1'b0, KEY);
        for (int k = 1; k <= 16; k++) begin
            vectors++; if (bus.subkey !== KS[k-1]) begin miscompares++; $display("FAIL mid_restart_subkey k=%0d: got %h expected %h", k, bus.subkey, KS[k-1]); end
            tick();
        end
        for (int h = 0; h < int'(LAST_HOLD); h++) tick();
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL mid_done_cnt: got %0d expected 0", bus.cnt); end
    endtask

    task automatic test_back_to_back();
        tick();
        apply_start(1'b0, KEY);
        for (int k = 1; k <= 16; k++) tick();
        for (int h = 0; h < int'(LAST_HOLD); h++) begin
            vectors++; if (bus.cnt !== 5'd17) begin miscompares++; $display("FAIL b2b_last h=%0d: got %0d expected 17", h, bus.cnt); end
            tick();
        end
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL b2b_gap_cnt: got %0d expected 0", bus.cnt); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_busy: got %b expected 0", bus.busy); end
        apply_start(1'b1, KEY);
        vectors++; if (bus.cnt !== 5'd1) begin miscompares++; $display("FAIL b2b_cnt: got %0d expected 1", bus.cnt); end
        vectors++; if (bus.subkey !== KS[15]) begin miscompares++; $display("FAIL b2b_subkey: got %h expected %h", bus.subkey, KS[15]); end
        for (int k = 1; k <= 16; k++) tick();
        for (int h = 0; h < int'(LAST_HOLD); h++) tick();
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL b2b_done_cnt: got %0d expected 0", bus.cnt); end
        vectors++; if (bus.subkey !== KS[0]) begin miscompares++; $display("FAIL b2b_done_subkey: got %h expected %h", bus.subkey, KS[0]); end
    endtask

    task automatic test_parity();
        tick();
`ifdef DES_KEY_PARITY_CHK_EN
        apply_start(1'b0, KEY_BADPAR);
        vectors++; if (bus.key_err !== 1'b1) begin miscompares++; $display("FAIL par_err_pulse: got %b expected 1", bus.key_err); end
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL par_rej_cnt: got %0d expected 0", bus.cnt); end
        vectors++; if (bus.subkey !== KS[0]) begin miscompares++; $display("FAIL par_rej_subkey: got %h expected %h", bus.subkey, KS[0]); end
        tick();
        vectors++; if (bus.key_err !== 1'b0) begin miscompares++; $display("FAIL par_err_len: got %b expected 0", bus.key_err); end
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL par_rej_cnt2: got %0d expected 0", bus.cnt); end
        apply_start(1'b0, KEY);
        vectors++; if (bus.key_err !== 1'b0) begin miscompares++; $display("FAIL par_ok_err: got %b expected 0", bus.key_err); end
        vectors++; if (bus.cnt !== 5'd1) begin miscompares++; $display("FAIL par_ok_cnt: got %0d expected 1", bus.cnt); end
        vectors++; if (bus.subkey !== KS[0]) begin miscompares++; $display("FAIL par_ok_subkey: got %h expected %h", bus.subkey, KS[0]); end
`else
        apply_start(1'b0, KEY_BADPAR);
        vectors++; if (bus.key_err !== 1'b0) begin miscompares++; $display("FAIL nopar_err: got %b expected 0", bus.key_err); end
        vectors++; if (bus.cnt !== 5'd1) begin miscompares++; $display("FAIL nopar_cnt: got %0d expected 1", bus.cnt); end
        vectors++; if (bus.subkey !== KS[0]) begin miscompares++; $display("FAIL nopar_subkey: got %h expected %h", bus.subkey, KS[0]); end
`endif
        for (int n = 0; n < 40 && bus.cnt !== 5'd0; n++) tick();
        vectors++; if (bus.cnt !== 5'd0) begin miscompares++; $display("FAIL par_drain: got %0d expected 0", bus.cnt); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        bus.key_in  = '0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
